// File: rtl/v4_pulse_gen_pkg.sv
// Shared settings for the v4 shaping chain: sample width, default decay and
// rise shifts, and the pulse generator state encoding.
package settings_v_4;

  localparam int SIZE_FILTER_DATA = 16;
  localparam int TAU_SHIFT_v_4    = 4;
  localparam int RISE_SHIFT_v_4   = 0;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_RISE,
    PG_DECAY
  } pg_state_t;

endpackage

// File: rtl/v4_pulse_gen_sat_add.sv
// Signed baseline plus unsigned magnitude, clamped to the signed DATA_W range.
// Shared with the shaper output stage, so it carries no state.
module v4_sat_add
  import settings_v_4::*;
#(
  parameter int DATA_W = SIZE_FILTER_DATA
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W:0]   b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W+1:0] sum;

  // Sign-extend the signed operand, zero-extend the magnitude, add at DATA_W+2 bits.
  assign sum = {{2{a[DATA_W-1]}}, a} + {1'b0, b};

  // Clamp when the top three bits disagree, i.e. the result left the DATA_W range.
  always_comb begin
    y = sum[DATA_W-1:0];
    if (sum[DATA_W+1] && (sum[DATA_W:DATA_W-1] != 2'b11))
      y = {1'b1, {(DATA_W-1){1'b0}}};
    else if (!sum[DATA_W+1] && (sum[DATA_W:DATA_W-1] != 2'b00))
      y = {1'b0, {(DATA_W-1){1'b1}}};
  end

endmodule

// File: rtl/v4_pulse_gen.sv
// Synthetic detector-pulse source: baseline plus a linear rise to a programmed
// amplitude followed by an exponential decay with tau of about 2^TAU_SHIFT samples.
// Optional macro V4_PULSE_PILEUP_EN: triggers are accepted in every state and
// add onto the pulse in flight (pile-up model).
//
// state    | meaning
// PG_IDLE  | acc held at zero, output follows baseline, ready for a trigger
// PG_RISE  | acc ramps by amp_q >> RISE_SHIFT, final cycle lands exactly on amp_q
// PG_DECAY | acc loses acc >> TAU_SHIFT per sample until below 2^TAU_SHIFT
module v4_pulse_gen
  import settings_v_4::*;
#(
  parameter int DATA_W     = SIZE_FILTER_DATA,
  parameter int TAU_SHIFT  = TAU_SHIFT_v_4,
  parameter int RISE_SHIFT = RISE_SHIFT_v_4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_valid,
  output logic              trig_ready,
  input  logic [DATA_W-1:0] trig_amp,
  input  logic [DATA_W-1:0] baseline,
  output logic [DATA_W-1:0] output_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'((1 << RISE_SHIFT) - 1);
  localparam logic [DATA_W:0]  DECAY_FLOOR = (DATA_W+1)'(1 << TAU_SHIFT);

  pg_state_t         state;
  logic [DATA_W:0]   acc;
  logic [DATA_W:0]   acc_next;
  logic [DATA_W-1:0] amp_q;
  logic [DATA_W-1:0] amp_eff;
  logic [DATA_W-1:0] rise_step;
  logic [CNT_W-1:0]  rise_cnt;
  logic [DATA_W-1:0] sample;
  logic              transfer;
  logic              pile_hit;
  logic              decay_exit;

`ifdef V4_PULSE_PILEUP_EN
  localparam logic [DATA_W:0] AMP_MAX = {1'b0, {DATA_W{1'b1}}};

  logic [DATA_W:0]   amp_sum;
  logic [DATA_W+1:0] pile_sum;
  logic [DATA_W:0]   pile_acc;

  // A trigger during RISE raises the target amplitude; one during DECAY adds onto acc.
  assign trig_ready = 1'b1;
  assign amp_sum    = {1'b0, amp_q} + {1'b0, trig_amp};
  assign pile_sum   = {1'b0, acc} + {2'b00, trig_amp};
  assign pile_acc   = (pile_sum > {1'b0, AMP_MAX}) ? AMP_MAX : pile_sum[DATA_W:0];
  assign amp_eff    = (transfer && (state == PG_RISE))
                    ? (amp_sum[DATA_W] ? {DATA_W{1'b1}} : amp_sum[DATA_W-1:0])
                    : amp_q;
  assign pile_hit   = transfer && (state == PG_DECAY);
`else
  assign trig_ready = (state == PG_IDLE);
  assign amp_eff    = amp_q;
  assign pile_hit   = 1'b0;
`endif

  assign transfer   = trig_valid && trig_ready;
  assign rise_step  = amp_eff >> RISE_SHIFT;
  assign decay_exit = (acc < DECAY_FLOOR) && !pile_hit;

  // Next accumulator value; the output register is fed from this so a sample
  // reflects the step taken on the same edge.
  always_comb begin
    acc_next = '0;
    case (state)
      PG_IDLE: acc_next = '0;
      PG_RISE: begin
        if (rise_cnt == RISE_LAST) acc_next = {1'b0, amp_eff};
        else                       acc_next = acc + {1'b0, rise_step};
      end
      PG_DECAY: begin
        if (acc < DECAY_FLOOR) acc_next = '0;
        else                   acc_next = acc - (acc >> TAU_SHIFT);
`ifdef V4_PULSE_PILEUP_EN
        if (pile_hit) acc_next = pile_acc;
`endif
      end
      default: acc_next = '0;
    endcase
  end

  v4_sat_add #(
    .DATA_W(DATA_W)
  ) u_sat_add (
    .a(baseline),
    .b(acc_next),
    .y(sample)
  );

  // Pulse FSM with registered sample, busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PG_IDLE;
      acc         <= '0;
      rise_cnt    <= '0;
      amp_q       <= '0;
      output_data <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      acc         <= acc_next;
      output_data <= sample;
      done        <= 1'b0;
      case (state)
        PG_IDLE: begin
          if (transfer) begin
            amp_q    <= trig_amp;
            rise_cnt <= '0;
            busy     <= 1'b1;
            state    <= PG_RISE;
          end
        end
        PG_RISE: begin
          amp_q <= amp_eff;
          if (rise_cnt == RISE_LAST) state <= PG_DECAY;
          else                       rise_cnt <= rise_cnt + 1'b1;
        end
        PG_DECAY: begin
          if (decay_exit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= PG_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= PG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v4_pulse_gen.sv
// Bench for v4_pulse_gen: a pulse-shape model (sequence of acc values per
// accepted trigger) checked every cycle against instance A, plus literal
// expectations for A and for a RISE_SHIFT=2 instance B.
module tb_v4_pulse_gen;
  import settings_v_4::*;

  localparam bit PILEUP =
`ifdef V4_PULSE_PILEUP_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid, b_valid;
  logic [15:0] a_amp, b_amp, a_base, b_base;
  logic        a_ready, b_ready, a_busy, b_busy, a_done, b_done;
  logic [15:0] a_out, b_out;

  int checks = 0;
  int failures = 0;

  int accq[$];
  int m_acc;
  bit m_rise;
  bit m_valid = 1'b0;
  bit m_xfer;
  int m_nxt;
  int exp_out, exp_busy, exp_done;
  int ramp_exp[5] = '{250, 500, 750, 1003, 941};

  always #5 clk = ~clk;

  v4_pulse_gen #(.DATA_W(16), .TAU_SHIFT(4), .RISE_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .trig_valid(a_valid), .trig_ready(a_ready),
    .trig_amp(a_amp), .baseline(a_base), .output_data(a_out),
    .busy(a_busy), .done(a_done)
  );

  v4_pulse_gen #(.DATA_W(16), .TAU_SHIFT(4), .RISE_SHIFT(2)) dut_b (
    .clk(clk), .reset(reset), .trig_valid(b_valid), .trig_ready(b_ready),
    .trig_amp(b_amp), .baseline(b_base), .output_data(b_out),
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int min_amp(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Pulse from a given start value: start, each decayed value, then the exit zero.
  task automatic load_pulse(input int start);
    int a;
    a = start;
    accq.delete();
    accq.push_back(a);
    while (a >= 16) begin
      a = a - (a >> 4);
      accq.push_back(a);
    end
    accq.push_back(0);
  endtask

  // Compare A against the model, then predict what the next edge must produce.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_out", int'($signed(a_out)), exp_out);
      chk("a_busy", int'(a_busy), exp_busy);
      chk("a_done", int'(a_done), exp_done);
      chk("a_ready", int'(a_ready), int'(PILEUP || (accq.size() == 0)));
    end
    if (reset) begin
      accq.delete();
      m_acc = 0; m_rise = 1'b0;
      exp_out = 0; exp_busy = 0; exp_done = 0;
    end else begin
      m_xfer = a_valid && (PILEUP || (accq.size() == 0));
      exp_done = 0;
      if (accq.size() == 0) begin
        m_nxt = 0;
        if (m_xfer) begin
          load_pulse(int'(a_amp));
          m_rise = 1'b1;
        end
      end else begin
        if (m_xfer) begin
          if (m_rise) load_pulse(min_amp(accq[0] + int'(a_amp)));
          else        load_pulse(min_amp(m_acc + int'(a_amp)));
        end
        m_nxt = accq.pop_front();
        m_rise = 1'b0;
        if (accq.size() == 0) exp_done = 1;
      end
      m_acc = m_nxt;
      exp_busy = (accq.size() != 0) ? 1 : 0;
      exp_out = sat16(int'($signed(a_base)) + m_nxt);
    end
    m_valid = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic trig_a(input int amp);
    a_amp = 16'(amp);
    a_valid = 1'b1;
    step(1);
    a_valid = 1'b0;
  endtask

  // Run A until idle; counts done pulses and non-decreasing samples while busy.
  task automatic run_to_done(input string name, input int budget,
                             output int ndone, output int nrise);
    int prev;
    ndone = 0;
    nrise = 0;
    prev = int'($signed(a_out));
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (a_done) ndone++;
      if (a_busy && (int'($signed(a_out)) >= prev)) nrise++;
      prev = int'($signed(a_out));
      if (!a_busy) break;
    end
    chk({name, "_idle"}, int'(a_busy), 0);
  endtask

  initial begin
    int nd, nr, cnt;
    a_valid = 1'b0; b_valid = 1'b0;
    a_amp = '0; b_amp = '0;
    a_base = 16'(-100); b_base = '0;
    reset = 1'b1;

    // 1. reset and baseline
    step(1);
    chk("rst_out", int'($signed(a_out)), 0);
    step(2);
    chk("rst_out3", int'($signed(a_out)), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_ready", int'(a_ready), 1);
    reset = 1'b0;
    step(1);
    chk("base_out", int'($signed(a_out)), -100);

    // 2. step pulse
    a_base = '0;
    step(1);
    trig_a(1000);
    chk("s2_accept_out", int'($signed(a_out)), 0);
    chk("s2_ready", int'(a_ready), PILEUP ? 1 : 0);
    step(1); chk("s2_peak", int'($signed(a_out)), 1000);
    step(1); chk("s2_d1", int'($signed(a_out)), 938);
    step(1); chk("s2_d2", int'($signed(a_out)), 880);
    step(1); chk("s2_d3", int'($signed(a_out)), 825);
    run_to_done("s2", 200, nd, nr);
    chk("s2_ndone", nd, 1);
    chk("s2_monotonic", nr, 0);
    chk("s2_tail", int'($signed(a_out)), 0);
    step(1);
    chk("s2_done_once", int'(a_done), 0);

    // 3. ramp on instance B
    b_amp = 16'd1003;
    b_valid = 1'b1;
    step(1);
    b_valid = 1'b0;
    chk("s3_accept_out", int'($signed(b_out)), 0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("s3_ramp", int'($signed(b_out)), ramp_exp[k]);
    end
    chk("s3_ready_busy", int'(b_ready), 0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!b_busy) break;
      step(1);
      if (b_done) cnt++;
    end
    chk("s3_idle", int'(b_busy), 0);
    chk("s3_ndone", cnt, 1);
    chk("s3_tail", int'($signed(b_out)), 0);

    // 4. saturation
    a_base = 16'd32000;
    step(1);
    trig_a(2000);
    step(1);
    chk("s4_clamp", int'($signed(a_out)), 32767);
    run_to_done("s4", 200, nd, nr);
    chk("s4_tail", int'($signed(a_out)), 32000);

    // 5. reset mid-decay
    a_base = '0;
    step(1);
    trig_a(1000);
    step(1);
    for (int i = 0; i < 40; i++) begin
      if (int'($signed(a_out)) <= 500) break;
      step(1);
    end
    chk("s5_reached", int'($signed(a_out)) <= 500, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("s5_out", int'($signed(a_out)), 0);
    chk("s5_busy", int'(a_busy), 0);
    chk("s5_done", int'(a_done), 0);
    step(1);
    chk("s5_done_after", int'(a_done), 0);
    trig_a(300);
    step(1); chk("s5_peak", int'($signed(a_out)), 300);
    step(1); chk("s5_d1", int'($signed(a_out)), 282);
    run_to_done("s5", 200, nd, nr);
    chk("s5_ndone", nd, 1);

    // 6. second trigger during decay
    trig_a(1000);
    step(3);
    chk("s6_pre", int'($signed(a_out)), 880);
    chk("s6_ready", int'(a_ready), PILEUP ? 1 : 0);
    trig_a(500);
    chk("s6_after", int'($signed(a_out)), PILEUP ? 1380 : 825);
    run_to_done("s6", 300, nd, nr);
    chk("s6_ndone", nd, 1);

    // 7. trigger held high with zero amplitude
    a_base = 16'(-5);
    a_amp = '0;
    a_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (a_done) cnt++;
      chk("s7_out", int'($signed(a_out)), -5);
    end
    a_valid = 1'b0;
    chk("s7_ndone", cnt, PILEUP ? 0 : 4);
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
